// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one LogicNets LUT layer: latches an input vector,
// walks the neurons one per cycle through a shared LUT RAM and assembles the output vector.
module lut_layer_sequencer #(
  parameter int NUM_IN      = 16,
  parameter int IN_BITS     = 2,
  parameter int FAN_IN      = 4,
  parameter int NUM_NEURONS = 8,
  parameter int OUT_BITS    = 2,
  parameter int ADDR_W      = FAN_IN * IN_BITS,
  parameter int NIDX_W      = $clog2(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN*IN_BITS-1:0]       in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NIDX_W+ADDR_W-1:0]        cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            busy,
  output logic [1:0]                      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // and its data hold steady until that edge, and ready never depends on valid.

  localparam int IN_W      = NUM_IN * IN_BITS;
  localparam int OUT_W     = NUM_NEURONS * OUT_BITS;
  localparam int LUT_DEPTH = 2 ** (NIDX_W + ADDR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NIDX_W-1:0]   nidx_q, nidx_d;
  logic [NIDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic                rd_pend_q, rd_pend_d;
  logic [IN_W-1:0]     act_q, act_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [OUT_BITS-1:0] lut_mem [LUT_DEPTH];
  logic [OUT_BITS-1:0] rd_data_q;
  logic [ADDR_W-1:0]   lut_addr;
  int                  act_idx;

  // Gather the fan-in of the neuron being issued into its LUT address.
  always_comb begin
    lut_addr = '0;
    act_idx  = 0;
    for (int k = 0; k < FAN_IN; k++) begin
      act_idx = (int'(nidx_q) * FAN_IN + k) % NUM_IN;
      lut_addr[k*IN_BITS +: IN_BITS] = act_q[act_idx*IN_BITS +: IN_BITS];
    end
  end

  always_comb begin
    state_d    = state_q;
    nidx_d     = nidx_q;
    act_d      = act_q;
    out_data_d = out_data_q;
    rd_pend_d  = 1'b0;
    rd_idx_d   = nidx_q;

    // Read data for the neuron issued on the previous edge lands in its slice.
    if (rd_pend_q && (state_q == EVAL || state_q == DRAIN)) begin
      out_data_d[int'(rd_idx_q)*OUT_BITS +: OUT_BITS] = rd_data_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EVAL;
          act_d   = in_data;
          nidx_d  = '0;
        end
      end
      EVAL: begin
        rd_pend_d = 1'b1;
        if (nidx_q == NIDX_W'(NUM_NEURONS - 1)) begin
          state_d = DRAIN;
          nidx_d  = '0;
        end else begin
          nidx_d = nidx_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nidx_q      <= '0;
      rd_idx_q    <= '0;
      rd_pend_q   <= 1'b0;
      act_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nidx_q      <= nidx_d;
      rd_idx_q    <= rd_idx_d;
      rd_pend_q   <= rd_pend_d;
      act_q       <= act_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // LUT RAM has no reset so its contents survive an aborted evaluation.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == IDLE) begin
      lut_mem[cfg_addr] <= cfg_data;
    end
    rd_data_q <= lut_mem[{nidx_q, lut_addr}];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: table of input vectors with hand-computed
// outputs plus sequences for backpressure, config lockout and mid-evaluation reset.
module tb_lut_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        cfg_we = 1'b0;
  logic [10:0] cfg_addr = '0;
  logic [1:0]  cfg_data = '0;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int e0     = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [31:0] in_d;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[7];

  lut_layer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input logic [2:0] n, input logic [7:0] a, input logic [1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = {n, a};
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic accept(input logic [31:0] d);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_out(input string name);
    int lat;
    logic [15:0] exp;
    exp = exp_q.pop_front();
    lat = cyc - e0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat = cyc - e0;
    end
    if (!out_valid) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_latency"}, lat, 9);
      check({name, "_data"}, out_data, exp);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_busy", busy, 0);
  endtask

  initial begin
    // acts 0..3 at bits 7:0, acts 8..11 at bits 23:16
    tbl[0] = '{32'h0000_00CC, 16'h0001};
    tbl[1] = '{32'h0000_001B, 16'h0300};
    tbl[2] = '{32'h00CC_00CC, 16'h0021};
    tbl[3] = '{32'h00CC_001B, 16'h0320};
    tbl[4] = '{32'h0000_0000, 16'h0000};
    tbl[5] = '{32'hFFFF_FFFF, 16'h0000};
    tbl[6] = '{32'h001B_0000, 16'h1000};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 2'd0);

    for (int i = 0; i < 2048; i++) begin
      logic [10:0] a;
      a = 11'(i);
      cfg_write(a[10:8], a[7:0], 2'b00);
    end
    cfg_write(3'd0, 8'hCC, 2'b01);
    cfg_write(3'd4, 8'h1B, 2'b11);
    cfg_write(3'd2, 8'hCC, 2'b10);
    cfg_write(3'd6, 8'h1B, 2'b01);

    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].in_d);
      check("eval_busy", busy, 1);
      check("eval_in_ready", in_ready, 0);
      exp_q.push_back(tbl[i].exp);
      wait_out($sformatf("vec%0d", i));
      handshake();
    end

    // Backpressure: output holds and a second vector is refused
    accept(32'h0000_001B);
    exp_q.push_back(16'h0300);
    wait_out("bp");
    in_valid = 1'b1;
    in_data  = 32'h0000_00CC;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 16'h0300);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_state_idle", dbg_state, 2'd0);

    // Config write during EVAL is ignored
    accept(32'h0000_00CC);
    repeat (2) begin @(posedge clk); #1; end
    cfg_write(3'd0, 8'hCC, 2'b10);
    exp_q.push_back(16'h0001);
    wait_out("cfg_eval_a");
    handshake();
    accept(32'h0000_00CC);
    exp_q.push_back(16'h0001);
    wait_out("cfg_eval_b");
    handshake();

    // Config write and acceptance on the same IDLE edge: evaluation sees new entry
    check("same_in_ready", in_ready, 1);
    cfg_we   = 1'b1;
    cfg_addr = {3'd0, 8'hCC};
    cfg_data = 2'b10;
    in_valid = 1'b1;
    in_data  = 32'h0000_00CC;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    e0 = cyc;
    exp_q.push_back(16'h0002);
    wait_out("same_edge");
    handshake();
    cfg_write(3'd0, 8'hCC, 2'b01);

    // Reset sampled at E3 aborts the evaluation; LUT survives
    accept(32'h0000_00CC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 16'h0000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, 2'd0);
    accept(32'h0000_00CC);
    exp_q.push_back(16'h0001);
    wait_out("after_rst");
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
